regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive debug-write wait cycles before the core is stalled (range 1..255).
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 core_we  input  1  core writeback write enable, covering RegWrite or Jal.
REQ-005 core_waddr  input  5  core writeback destination register.
REQ-006 core_wdata  input  32  core writeback data.
REQ-007 core_stall  output  1  holds the core writeback for this cycle.
REQ-008 dbg_req  input  1  debug access request; one-cycle pulse, sampled only in IDLE.
REQ-009 dbg_we  input  1  debug access type: 1 write, 0 read.
REQ-010 dbg_addr  input  5  debug register address.
REQ-011 dbg_wdata  input  32  debug write data.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 dbg_rdata  output  32  debug read result; valid while dbg_ack=1 and held until the next read.
REQ-014 busy  output  1  high while a debug access is outstanding.
REQ-015 rf_we, rf_waddr, rf_wdata  output  1/5/32  register-file write port.
REQ-016 rf_raddr  output  5  register-file debug read address.
REQ-017 rf_rdata  input  32  register-file debug read data, combinational from rf_raddr.

Function
REQ-018 FSM states: IDLE, PEND, ACK; busy = (state != IDLE).
REQ-019 IDLE: dbg_req=1 latches dbg_we/dbg_addr/dbg_wdata into a hold register and moves to PEND.
REQ-020 dbg_req arriving outside IDLE is ignored; no queueing and no ack.
REQ-021 PEND read: rf_raddr = held address; rf_rdata is captured into dbg_rdata at the edge, then the FSM moves to ACK; reads never wait on core_we.
REQ-022 PEND write with core_we=0: rf_we=1, rf_waddr/rf_wdata = held values, then the FSM moves to ACK.
REQ-023 PEND write with core_we=1: the core has priority and passes through; the FSM stays in PEND and wait_cnt increments.
REQ-024 A debug write to register 0 completes and acks with rf_we=0.
REQ-025 ACK: dbg_ack=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 Uncontended latency: dbg_req at edge N gives the access in cycle N+1 and dbg_ack in cycle N+2.
REQ-027 Outside a debug grant, rf_we/rf_waddr/rf_wdata = core_we/core_waddr/core_wdata.
REQ-028 rf_raddr = 0 when not in PEND.
REQ-029 wait_cnt is 8 bits and clears on entry to PEND.
REQ-030 wait_cnt saturates at STARVE_LIMIT and never wraps.

Reset
REQ-031 Reset forces: state IDLE; wait_cnt 0; hold register 0; dbg_rdata 0; dbg_ack 0; core_stall 0; busy 0.
REQ-032 Reset during PEND or ACK aborts the access: no register-file write, no ack.

Configuration
REQ-033 Macro REGARB_STARVE_EN defined: in PEND write with wait_cnt == STARVE_LIMIT, core_stall=1 combinationally and the debug write wins that cycle.
REQ-034 Under REGARB_STARVE_EN, the core write is not performed in the forced cycle; the core re-presents it next cycle.
REQ-035 Macro undefined: wait_cnt is absent, core_stall is tied 0, and a debug write waits indefinitely while core_we=1.

Structure
REQ-036 Shared package regarb_pkg holds: the state enum, REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0.
REQ-037 A single flat module is used, with no sub-modules.

Verification
REQ-038 Uncontended write: dbg_req with we=1, addr=5, wdata=0xDEADBEEF, core_we=0 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; dbg_ack in cycle N+2.
REQ-039 Read: with rf_rdata=0x12345678 for addr 9, a dbg read of addr 9 -> rf_raddr=9 in PEND; dbg_ack with dbg_rdata=0x12345678.
REQ-040 Starvation with REGARB_STARVE_EN and STARVE_LIMIT=3: core_we held 1 -> core_stall=1 exactly on the 4th PEND cycle, carrying the debug write; dbg_ack next cycle.
REQ-041 Starvation without the macro: core_we held 1 for 20 cycles -> no rf_we from debug and core_stall=0 throughout; write and ack occur after core_we drops.
REQ-042 Register-0 write (addr 0, wdata 0xFFFFFFFF) -> rf_we=0 during the grant cycle, and dbg_ack is still issued.
REQ-043 Reset asserted mid-PEND -> busy=0 immediately, no rf_we from debug, no dbg_ack.
REQ-044 A dbg_req pulse sent while busy=1 is dropped, giving exactly one ack.

Source files
------------

// File: rtl/regarb_pkg.sv
// regarb_pkg: shared FSM state type and widths for the register-file port arbiter
package regarb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
endpackage

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register-file write port between core writeback and a debug port
// Ports: clock, reset (async, active-high)
//   core_we/core_waddr/core_wdata in, core_stall out    : core writeback, stalled when debug is forced through
//   dbg_req/dbg_we/dbg_addr/dbg_wdata in                 : single-shot debug access, accepted only when idle
//   dbg_ack/dbg_rdata/busy out                           : completion pulse, read result, access outstanding
//   rf_we/rf_waddr/rf_wdata/rf_raddr out, rf_rdata in    : register-file write port and debug read port
// Option: REGARB_STARVE_EN forces a blocked debug write through after STARVE_LIMIT waiting cycles.
module regfile_port_arbiter
  import regarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata
);
  state_t state_q, state_d;
  logic hold_we_q, hold_we_d;
  logic [REG_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d, rdata_q, rdata_d;
  logic pend, pend_wr, force_wr, grant;
  assign pend = state_q == PEND;
  assign pend_wr = pend && hold_we_q;
`ifdef REGARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  assign force_wr = wait_cnt_q == LIMIT;
  // counting stops at the limit because the forced write leaves PEND that same cycle
  assign wait_cnt_d = (state_q == IDLE && dbg_req) ? 8'd0
                    : (pend_wr && core_we && !force_wr) ? wait_cnt_q + 8'd1
                    : wait_cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) wait_cnt_q <= 8'd0;
    else wait_cnt_q <= wait_cnt_d;
`else
  logic unused_limit;
  assign unused_limit = ^8'(STARVE_LIMIT);
  assign force_wr = 1'b0;
`endif
  // the debug write owns the port when the core is quiet or when it has starved too long
  assign grant = pend_wr && (!core_we || force_wr);
  assign core_stall = pend_wr && force_wr;
  assign busy = state_q != IDLE;
  assign dbg_ack = state_q == ACK;
  assign dbg_rdata = rdata_q;
  assign rf_we = grant ? hold_addr_q != ZERO_REG : core_we;
  assign rf_waddr = grant ? hold_addr_q : core_waddr;
  assign rf_wdata = grant ? hold_wdata_q : core_wdata;
  assign rf_raddr = pend ? hold_addr_q : ZERO_REG;
  always_comb begin
    state_d = state_q;
    hold_we_d = hold_we_q;
    hold_addr_d = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && dbg_req) begin
      state_d = PEND;
      hold_we_d = dbg_we;
      hold_addr_d = dbg_addr;
      hold_wdata_d = dbg_wdata;
    end else if (pend && !hold_we_q) begin
      state_d = ACK;
      rdata_d = rf_rdata;
    end else if (grant) begin
      state_d = ACK;
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      hold_we_q <= 1'b0;
      hold_addr_q <= ZERO_REG;
      hold_wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hold_we_q <= hold_we_d;
      hold_addr_q <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: vector table, corner sequences and random traffic against a transaction model
module tb_regfile_port_arbiter;
  localparam int LIMIT = 3;
`ifdef REGARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic core_we = 1'b0;
  logic [4:0] core_waddr = 5'd0;
  logic [31:0] core_wdata = 32'd0;
  logic core_stall;
  logic dbg_req = 1'b0;
  logic dbg_we = 1'b0;
  logic [4:0] dbg_addr = 5'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic dbg_ack, busy, rf_we;
  logic [31:0] dbg_rdata, rf_wdata, rf_rdata;
  logic [4:0] rf_waddr, rf_raddr;
  int checks = 0;
  int failures = 0;
  bit m_busy, m_ackdue, m_we;
  logic [4:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  int m_wait;

  typedef struct {
    logic req; logic we; logic [4:0] a; logic [31:0] d;
    logic cwe; logic [4:0] ca; logic [31:0] cd;
    logic e_we; logic [4:0] e_waddr; logic [31:0] e_wdata; logic [4:0] e_raddr;
    logic e_ack; logic e_busy; logic e_stall; logic [31:0] e_rdata;
  } vec_t;
  vec_t vecs[16];

  regfile_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd9) ? 32'h12345678 : {8'hA0, 19'd0, a};
  endfunction
  assign rf_rdata = rf_val(rf_raddr);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ackdue = 1'b0; m_we = 1'b0;
    m_addr = 5'd0; m_wdata = 32'd0; m_rdata = 32'd0; m_wait = 0;
  endtask

  // expected outputs follow from the outstanding access and how long it has waited
  task automatic model_check();
    bit pend, frc, dw;
    pend = m_busy && !m_ackdue;
    frc = STARVE_EN && pend && m_we && m_wait >= LIMIT;
    dw = pend && m_we && (!core_we || frc);
    chk("m_rf_we", 32'(rf_we), 32'(dw ? (m_addr != 5'd0) : core_we));
    chk("m_rf_waddr", 32'(rf_waddr), 32'(dw ? m_addr : core_waddr));
    chk("m_rf_wdata", rf_wdata, dw ? m_wdata : core_wdata);
    chk("m_rf_raddr", 32'(rf_raddr), 32'(pend ? m_addr : 5'd0));
    chk("m_core_stall", 32'(core_stall), 32'(frc));
    chk("m_dbg_ack", 32'(dbg_ack), 32'(m_ackdue));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_dbg_rdata", dbg_rdata, m_rdata);
  endtask

  task automatic model_advance();
    if (m_ackdue) begin
      m_busy = 1'b0; m_ackdue = 1'b0;
    end else if (m_busy) begin
      if (!m_we) begin
        m_rdata = rf_val(m_addr); m_ackdue = 1'b1;
      end else if (!core_we || (STARVE_EN && m_wait >= LIMIT)) m_ackdue = 1'b1;
      else m_wait++;
    end else if (dbg_req) begin
      m_busy = 1'b1; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; m_wait = 0;
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic cwe, input logic [4:0] ca, input logic [31:0] cd);
    @(negedge clock);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    core_we = cwe; core_waddr = ca; core_wdata = cd;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clock);
    model_advance();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77,  1'b1, 5'd7, 32'h77, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33,  1'b1, 5'd3, 32'h33, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h12345678};
    vecs[10] = '{1'b1, 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[11] = '{1'b1, 1'b1, 5'd13, 32'hDDDD, 1'b1, 5'd1, 32'h11,  1'b1, 5'd1, 32'h11, 5'd12, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 32'hC0C0, 5'd12, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[13] = '{1'b1, 1'b1, 5'd14, 32'hEEEE, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h12345678};
    vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[15] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].cwe, vecs[i].ca, vecs[i].cd);
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_rf_raddr", i), 32'(rf_raddr), 32'(vecs[i].e_raddr));
      chk($sformatf("v%0d_ack", i), 32'(dbg_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_rdata", i), dbg_rdata, vecs[i].e_rdata);
      tick();
    end
    // starvation: core keeps writing while a debug write waits
    drive(1'b1, 1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
      chk($sformatf("starve%0d_stall", i), 32'(core_stall), 32'(STARVE_EN && i == LIMIT));
      chk($sformatf("starve%0d_waddr", i), 32'(rf_waddr), (STARVE_EN && i == LIMIT) ? 32'd20 : 32'd2);
      chk($sformatf("starve%0d_ack", i), 32'(dbg_ack), 32'(STARVE_EN && i == LIMIT + 1));
      chk($sformatf("starve%0d_busy", i), 32'(busy), 32'(!STARVE_EN || i <= LIMIT + 1));
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_release_we", 32'(rf_we), 32'(!STARVE_EN));
    chk("starve_release_waddr", 32'(rf_waddr), STARVE_EN ? 32'd0 : 32'd20);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_release_ack", 32'(dbg_ack), 32'(!STARVE_EN));
    tick();
    // reset while a debug write waits in PEND
    drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    @(negedge clock);
    core_we = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(dbg_ack), 32'd0);
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_raddr", 32'(rf_raddr), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk($sformatf("postrst%0d_ack", i), 32'(dbg_ack), 32'd0);
      chk($sformatf("postrst%0d_rf_we", i), 32'(rf_we), 32'd0);
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
